// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start bit, 8 data bits LSB first, odd parity, stop, ack.
// Latency: INHIBIT_CYCLES + 1 clk before the clock line is released, then 11 device clock falls plus line-idle wait.
// Backpressure: tx_ready is high only in IDLE; tx_valid outside IDLE is ignored and the held byte is taken on return.
// Optional device-clock timeout is built when PS2_HOST_TX_TIMEOUT_EN is defined.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_ack_ok,
  output logic       tx_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  // Inhibit counter runs 0 .. INHIBIT_CYCLES-1
  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic             data_oe_q, data_oe_d;
  logic             ack_q, ack_d;
  logic             done_d, ack_ok_d, err_d;

  // Line synchronisers; reset to the idle (high) level so reset never fakes a falling edge
  logic [1:0] clk_sync_q, data_sync_q;
  logic       clk_prev_q;
  logic       clk_cur, data_cur, clk_fall;

  assign clk_cur  = clk_sync_q[1];
  assign data_cur = data_sync_q[1];
  assign clk_fall = clk_prev_q & ~clk_cur;

`ifdef PS2_HOST_TX_TIMEOUT_EN
  // Timeout counter runs 0 .. TIMEOUT_CYCLES-1 between progress events
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q;
  logic            frame_active;
  logic            progress;
`else
  // Timeout disabled: the parameter stays on the interface so both builds share one instantiation
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  // Two-flop synchronisers plus previous clock level for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  // Next-state and datapath decisions for the frame sequencer
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    data_oe_d = data_oe_q;
    ack_d     = ack_q;
    done_d    = 1'b0;
    ack_ok_d  = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        data_oe_d = 1'b0;
        if (tx_valid) begin
          shift_d   = tx_data;
          parity_d  = ~^tx_data;
          inh_cnt_d = '0;
          state_d   = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = S_START;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end

      S_START: begin
        bit_cnt_d = '0;
        state_d   = S_DATA;
      end

      S_DATA: begin
        if (clk_fall) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'd7) begin
            state_d = S_PARITY;
          end
        end
      end

      S_PARITY: begin
        if (clk_fall) begin
          data_oe_d = ~parity_q;
          state_d   = S_STOP;
        end
      end

      S_STOP: begin
        if (clk_fall) begin
          data_oe_d = 1'b0;
          state_d   = S_ACK;
        end
      end

      S_ACK: begin
        if (clk_fall) begin
          ack_d   = ~data_cur;
          state_d = S_WAIT_IDLE;
        end
      end

      S_WAIT_IDLE: begin
        if (clk_cur && data_cur) begin
          done_d   = 1'b1;
          ack_ok_d = ack_q;
          state_d  = S_IDLE;
        end
      end

      default: begin
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
    // A clock fall (or leaving WAIT_IDLE) restarts the window; expiry aborts the frame
    to_cnt_d = to_cnt_q;
    if (state_q == S_START) begin
      to_cnt_d = '0;
    end else if (frame_active) begin
      if (progress) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TO_LAST) begin
        to_cnt_d  = '0;
        data_oe_d = 1'b0;
        done_d    = 1'b1;
        ack_ok_d  = 1'b0;
        err_d     = 1'b1;
        state_d   = S_IDLE;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
`endif
  end

`ifdef PS2_HOST_TX_TIMEOUT_EN
  assign frame_active = (state_q == S_DATA) || (state_q == S_PARITY) || (state_q == S_STOP) ||
                        (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
  assign progress     = clk_fall || ((state_q == S_WAIT_IDLE) && clk_cur && data_cur);

  // Timeout counter and registered error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign tx_error = err_q;
`else
  assign tx_error = 1'b0;
`endif

  // Sequencer state, shift register, counters and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      data_oe_q <= 1'b0;
      ack_q     <= 1'b0;
      tx_done   <= 1'b0;
      tx_ack_ok <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      data_oe_q <= data_oe_d;
      ack_q     <= ack_d;
      tx_done   <= done_d;
      tx_ack_ok <= ack_ok_d;
    end
  end

  // The clock line is pulled low only while inhibiting and during the start-bit cycle
  assign ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_START);
  assign ps2_data_oe = data_oe_q;
  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model, PS/2 device model, frame reference model.
// Device clock is scaled down (half period 12..24 clk) together with small inhibit/timeout values.
// Define PS2_HOST_TX_TIMEOUT_EN to exercise the timeout path; otherwise the stall case checks it never aborts.
module tb_ps2_host_tx;

  localparam int INH = 40;
  localparam int TO  = 300;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, tx_done, tx_ack_ok, tx_error;

  logic dev_clk_low, dev_data_low;
  logic clk_line, data_line;

  assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (clk_line),
    .ps2_data_in (data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_ack_ok   (tx_ack_ok),
    .tx_error    (tx_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observers: done pulses with their flags, inhibit length, stray status flags
  int         done_cnt = 0;
  logic       last_ack, last_err, last_rdy;
  logic [1:0] last_oe;
  int         inh_run = 0;
  int         inh_len = 0;
  int         stray_cnt = 0;

  always @(negedge clk) begin
    if (tx_done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      last_ack <= tx_ack_ok;
      last_err <= tx_error;
      last_rdy <= tx_ready;
      last_oe  <= {ps2_clk_oe, ps2_data_oe};
    end
    if (tx_done !== 1'b1 && (tx_ack_ok !== 1'b0 || tx_error !== 1'b0)) stray_cnt <= stray_cnt + 1;
    if (ps2_clk_oe && !ps2_data_oe) inh_run <= inh_run + 1;
    else if (ps2_clk_oe && ps2_data_oe) inh_len <= inh_run;
    else inh_run <= 0;
  end

  initial begin
    #700000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame as the device should see it: start, data LSB first, odd parity, stop
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    ones = 0;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      f[1 + i] = d[i];
      if (d[i]) ones++;
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Device: waits for the inhibit and clock release, then clocks npulse falling edges,
  // sampling on each rising edge and driving the ack between pulses 10 and 11
  task automatic device_frame(input bit ack_low, input int npulse,
                              output logic [10:0] got, output bit started);
    int t;
    int hp;
    got = '0;
    started = 0;
    t = 0;
    while (!(busy && !clk_line) && t < INH + 50) begin @(negedge clk); t++; end
    while (!clk_line && t < 2 * INH + 100) begin @(negedge clk); t++; end
    if (busy && clk_line) begin
      started = 1;
      got[0] = data_line;
      for (int p = 1; p <= npulse; p++) begin
        hp = int'($urandom_range(24, 12));
        repeat (hp) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (hp) @(negedge clk);
        dev_clk_low = 1'b0;
        if (p <= 10) got[p] = data_line;
        if (p == 10 && ack_low) dev_data_low = 1'b1;
        if (p == 11) dev_data_low = 1'b0;
      end
    end
  endtask

  task automatic wait_done(input int n0, input int lim, output bit seen, output int el);
    el = 0;
    while (done_cnt == n0 && el < lim) begin @(negedge clk); el++; end
    seen = (done_cnt != n0);
  endtask

  task automatic request(input logic [7:0] d, input string tag);
    int t;
    @(negedge clk);
    tx_data = d;
    tx_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (tx_ready && t < 10);
    check({tag, "_accepted"}, {31'd0, busy}, 32'd1);
    tx_valid = 1'b0;
  endtask

  // Device side of a complete frame plus the done-pulse checks
  task automatic full_frame(input logic [7:0] d, input bit ack_low, input string tag);
    logic [10:0] got;
    bit st, seen;
    int n0, el;
    n0 = done_cnt;
    device_frame(ack_low, 11, got, st);
    check({tag, "_started"}, {31'd0, st}, 32'd1);
    check({tag, "_inhibit_ge"}, {31'd0, inh_len >= INH}, 32'd1);
    check({tag, "_frame"}, {21'd0, got}, {21'd0, model_frame(d)});
    wait_done(n0, 100, seen, el);
    check({tag, "_done"}, {31'd0, seen}, 32'd1);
    check({tag, "_ack_ok"}, {31'd0, last_ack}, {31'd0, ack_low});
    check({tag, "_error"}, {31'd0, last_err}, 32'd0);
    check({tag, "_ready_at_done"}, {31'd0, last_rdy}, 32'd1);
  endtask

  initial begin
    logic [10:0] got;
    bit st, seen;
    int n0, el;
    logic [7:0] rb;
    bit ra;

    rst = 1'b1;
    tx_valid = 1'b0;
    tx_data = '0;
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("rst_flags", {29'd0, tx_done, tx_ack_ok, tx_error}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Directed bytes, including the parity corner cases
    request(8'hED, "ed");
    full_frame(8'hED, 1'b1, "ed");
    request(8'hF4, "f4");
    full_frame(8'hF4, 1'b1, "f4");
    request(8'h00, "b00");
    full_frame(8'h00, 1'b1, "b00");
    request(8'hFF, "bff");
    full_frame(8'hFF, 1'b1, "bff");

    // Device leaves the ack slot high
    request(8'h5A, "noack");
    full_frame(8'h5A, 1'b0, "noack");

    // Random bytes with random ack behaviour
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom);
      ra = 1'($urandom);
      request(rb, "rand");
      full_frame(rb, ra, "rand");
    end

    // Reset in the middle of the data bits
    request(8'hA5, "rstmid");
    device_frame(1'b1, 3, got, st);
    check("rstmid_started", {31'd0, st}, 32'd1);
    n0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_ready", {31'd0, tx_ready}, 32'd1);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("rstmid_no_done", done_cnt, n0);
    request(8'hF4, "after_rst");
    full_frame(8'hF4, 1'b1, "after_rst");

    // tx_valid held with a second byte while the first frame runs
    @(negedge clk);
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    el = 0;
    do begin @(negedge clk); el++; end while (tx_ready && el < 10);
    check("hold_first_accept", {31'd0, busy}, 32'd1);
    tx_data = 8'hC9;
    full_frame(8'h3C, 1'b1, "hold_first");
    el = 0;
    while (tx_ready && el < 20) begin @(negedge clk); el++; end
    check("hold_second_accept", {31'd0, busy}, 32'd1);
    tx_valid = 1'b0;
    full_frame(8'hC9, 1'b1, "hold_second");

`ifdef PS2_HOST_TX_TIMEOUT_EN
    // Device stops clocking after four bits
    request(8'h96, "timeout");
    n0 = done_cnt;
    device_frame(1'b1, 4, got, st);
    check("timeout_started", {31'd0, st}, 32'd1);
    wait_done(n0, TO + 100, seen, el);
    check("timeout_done", {31'd0, seen}, 32'd1);
    check("timeout_window", {31'd0, (el >= TO - 30) && (el <= TO + 5)}, 32'd1);
    check("timeout_error", {31'd0, last_err}, 32'd1);
    check("timeout_ack_ok", {31'd0, last_ack}, 32'd0);
    check("timeout_oe", {30'd0, last_oe}, 32'd0);
    check("timeout_ready", {31'd0, last_rdy}, 32'd1);
`else
    // Without the timeout the host waits on a stalled device until reset
    request(8'h96, "stall");
    n0 = done_cnt;
    device_frame(1'b1, 4, got, st);
    check("stall_started", {31'd0, st}, 32'd1);
    repeat (3 * TO) @(negedge clk);
    check("stall_no_done", done_cnt, n0);
    check("stall_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("stall_rst_busy", {31'd0, busy}, 32'd0);
`endif

    // Status flags never appear outside a done pulse
    repeat (5) @(negedge clk);
    check("stray_flags", stray_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte, e.g. keyboard LED set 0xED or mouse enable 0xF4, to the attached device.
- Pairs with the team's PS/2 receiver on the same two lines. The top level owns the open-drain tristates (line = 0 when oe=1, else Z with pull-up) and shares the synchronised line inputs with the receiver.
- The receiver must ignore line traffic while busy=1.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles the host holds PS/2 clock low before the start bit (100 us at 50 MHz)
TIMEOUT_CYCLES, 750000, max clk cycles allowed between successive device clock falling edges (15 ms at 50 MHz)

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous reset, active-high
tx_data  input  8  byte to send, LSB first
tx_valid  input  1  request; accepted when tx_valid && tx_ready
tx_ready  output  1  high only in IDLE
ps2_clk_in  input  1  raw PS/2 clock line level
ps2_data_in  input  1  raw PS/2 data line level
ps2_clk_oe  output  1  1 = pull PS/2 clock low
ps2_data_oe  output  1  1 = pull PS/2 data low
busy  output  1  high in every state except IDLE
tx_done  output  1  one-cycle pulse when the frame ends (success or error)
tx_ack_ok  output  1  valid with tx_done; 1 = device drove the ack bit low
tx_error  output  1  valid with tx_done; 1 = timeout

Behaviour:
- Reset (synchronous, any state): state=IDLE, both oe=0, tx_ready=1, busy=0, tx_done/tx_ack_ok/tx_error=0, counters=0. Lines are released one clk after rst is sampled.
- Input sync: 2-flop synchroniser on each line, plus a registered previous value of the clock line.
  - clk_fall = prev & ~cur.
  - Raw line edge to clk_fall takes 3 clk cycles.
- Accept: on tx_valid && tx_ready, latch tx_data into shift_q[7:0] and parity_q = ~^tx_data (odd parity). Go to INHIBIT on the next clk.
- IDLE: oe both 0; tx_ready=1.
- INHIBIT: ps2_clk_oe=1, ps2_data_oe=0. Count INHIBIT_CYCLES, then go to START.
- START: ps2_clk_oe=1, ps2_data_oe=1 (start bit = 0) for exactly 1 clk. Then ps2_clk_oe=0; go to DATA with bit_cnt=0 and the timeout counter cleared.
- DATA: hold data_oe=1 until clk_fall.
  - On each clk_fall: ps2_data_oe = ~shift_q[0], shift right, bit_cnt++.
  - After the 8th bit is presented, go to PARITY.
- PARITY: on clk_fall, ps2_data_oe = ~parity_q.
- STOP: on clk_fall, ps2_data_oe=0 (release = stop bit 1).
- ACK: on clk_fall, sample synchronised data; ack_q = ~data. Go to WAIT_IDLE.
- WAIT_IDLE: wait until both synchronised lines are 1. Then pulse tx_done=1, tx_ack_ok=ack_q, tx_error=0, and return to IDLE. tx_ready rises on the same clk.
- Frame edge count: device falling edges after START = 11 (8 data, parity, stop, ack).
- Timeout (feature below): any state from DATA through WAIT_IDLE with no clk_fall/exit condition for TIMEOUT_CYCLES triggers:
  - both oe=0
  - tx_done=1, tx_error=1, tx_ack_ok=0
  - state=IDLE
- Simultaneous events:
  - tx_valid during busy is ignored. The held byte is taken once back in IDLE.
  - rst wins over every event.
  - clk_fall and timeout expiry in the same cycle: clk_fall wins, counter clears.
- Outputs tx_done/tx_ack_ok/tx_error are zero except during the done pulse.

Optional Feature:
PS2_HOST_TX_TIMEOUT_EN
- Defined: timeout counter and tx_error path are built as described above.
- Undefined:
  - No counter is synthesised.
  - tx_error is tied to 0.
  - The FSM waits indefinitely for device clock edges. Only rst recovers a stuck frame.

Test Plan:
- tx_data=0xED, device model clocks at 12.5 kHz and acks low.
  - Required: clock held low ≥ INHIBIT_CYCLES.
  - Device samples start=0, bits 1,0,1,1,0,1,1,1, parity=1, stop=1.
  - tx_done with tx_ack_ok=1, tx_error=0.
- tx_data=0xF4: device samples bits 0,0,1,0,1,1,1,1 and parity=0. 0x00 gives parity=1; 0xFF gives parity=1.
- Device leaves data high in the ack slot: tx_done=1, tx_ack_ok=0, tx_error=0.
- Device stops clocking after 4 bits (macro defined): after TIMEOUT_CYCLES, tx_done=1 with tx_error=1. Both oe=0 and tx_ready=1 on the next cycle.
- rst asserted mid-DATA: next clk gives both oe=0, busy=0, tx_ready=1, and no tx_done pulse. A new 0xF4 request afterwards sends correctly.
- tx_valid held high with a second byte during a frame: only the first is sent until tx_ready returns. The second is then latched and sent intact.
